// File: rtl/fifo_axis_reader_if.sv
// Bus bundle between the FIFO-read / AXI4-Stream reader and its environment.
// master = the reader (pops the FIFO, drives the stream); slave = FIFO + sink.
interface fifo_axis_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    input  fifo_rd_data, fifo_empty, m_axis_tready,
    output fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output fifo_rd_data, fifo_empty, m_axis_tready,
    input  fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/fifo_axis_reader.sv
// Read-side consumer of a first-word-fall-through FIFO. Pops words into a
// 2-entry (main + skid) buffer and presents them as an AXI4-Stream master,
// framed into PACKET_LEN-beat packets. enable=0 stops only on packet
// boundaries. The pop strobe depends on registered state only, so there is
// no combinational path from m_axis_tready to fifo_rd_en.
module fifo_axis_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int PACKET_LEN  = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  fifo_axis_reader_if.master     bus,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic [COUNT_WIDTH-1:0] packet_count
);

  localparam int IDX_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state, state_nxt;
  beat_t            main_q, skid_q, pop_beat;
  logic             main_vld, skid_vld;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             run_ok, pop, pop_last, hs;

  // Skid is only ever filled behind an occupied main, so occupancy<2 == ~skid.
  assign pop_last = (idx == IDX_W'(PACKET_LEN - 1));
  assign hs       = main_vld & bus.m_axis_tready;
  assign pop_beat = '{data: bus.fifo_rd_data, last: pop_last};
  assign idx_nxt  = pop ? (pop_last ? '0 : idx + IDX_W'(1)) : idx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: stopping is decided on the index after this cycle's pop, so
  // a pop landing on the packet boundary ends the stream cleanly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = (idx_nxt == '0) ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)               state_nxt = RUN;
        else if (pop && pop_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: pop whenever streaming, data present and buffer has room
  always_comb begin
    run_ok = (state == RUN) || (state == DRAIN);
    pop    = run_ok && !bus.fifo_empty && !skid_vld;
  end

  // Beat index within the packet, advanced per pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx <= '0;
    else        idx <= idx_nxt;
  end

  // Main/skid buffer: popped word fills main if it is free or leaving,
  // otherwise the skid; a handshake promotes the skid into main.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (hs) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= pop;
        if (pop) main_q <= pop_beat;
      end
    end else if (pop) begin
      if (!main_vld) begin
        main_q   <= pop_beat;
        main_vld <= 1'b1;
      end else begin
        skid_q   <= pop_beat;
        skid_vld <= 1'b1;
      end
    end
  end

  // Statistics: accepted beats and accepted packet ends, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count   <= '0;
      packet_count <= '0;
    end else if (hs) begin
      word_count <= word_count + COUNT_WIDTH'(1);
      if (main_q.last) packet_count <= packet_count + COUNT_WIDTH'(1);
    end
  end

  assign bus.fifo_rd_en    = pop;
  assign bus.m_axis_tdata  = main_q.data;
  assign bus.m_axis_tlast  = main_q.last;
  assign bus.m_axis_tvalid = main_vld;
  assign busy              = (state != IDLE) || main_vld;

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench: instance 0 uses PACKET_LEN=8, instance 1 uses PACKET_LEN=1.
// Each instance has a small FWFT FIFO model and a negedge stream monitor.
module tb_fifo_axis_reader;
  localparam int DW = 16;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0;
  logic busy_a, busy_b;
  logic [CW-1:0] wc_a, pc_a, wc_b, pc_b;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fifo_axis_reader_if #(.DATA_WIDTH(DW)) if_a ();
  fifo_axis_reader_if #(.DATA_WIDTH(DW)) if_b ();

  fifo_axis_reader #(.DATA_WIDTH(DW), .PACKET_LEN(8), .COUNT_WIDTH(CW)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .bus(if_a.master),
    .busy(busy_a), .word_count(wc_a), .packet_count(pc_a));

  fifo_axis_reader #(.DATA_WIDTH(DW), .PACKET_LEN(1), .COUNT_WIDTH(CW)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .bus(if_b.master),
    .busy(busy_b), .word_count(wc_b), .packet_count(pc_b));

  // FWFT FIFO models
  logic [DW-1:0] mem [2][64];
  int wp [2];
  int rp [2];

  assign if_a.fifo_empty   = (rp[0] == wp[0]);
  assign if_a.fifo_rd_data = mem[0][rp[0] % 64];
  assign if_b.fifo_empty   = (rp[1] == wp[1]);
  assign if_b.fifo_rd_data = mem[1][rp[1] % 64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp[0] <= 0;
      rp[1] <= 0;
    end else begin
      if (if_a.fifo_rd_en) rp[0] <= rp[0] + 1;
      if (if_b.fifo_rd_en) rp[1] <= rp[1] + 1;
    end
  end

  // Per-instance views for the monitor
  logic          tv [2], tr [2], tl [2], re [2], bs [2];
  logic [DW-1:0] td [2];
  assign tv[0] = if_a.m_axis_tvalid; assign tv[1] = if_b.m_axis_tvalid;
  assign tr[0] = if_a.m_axis_tready; assign tr[1] = if_b.m_axis_tready;
  assign tl[0] = if_a.m_axis_tlast;  assign tl[1] = if_b.m_axis_tlast;
  assign td[0] = if_a.m_axis_tdata;  assign td[1] = if_b.m_axis_tdata;
  assign re[0] = if_a.fifo_rd_en;    assign re[1] = if_b.fifo_rd_en;
  assign bs[0] = busy_a;             assign bs[1] = busy_b;

  logic [DW-1:0] cap_d [2][32];
  logic          cap_l [2][32];
  int            cap_c [2][32];
  int cap_n [2], stab_err [2], ovf_err [2], occ [2];
  int rd_cnt [2], rd_first [2], rd_lastc [2], busy_fall [2];
  logic prev_stall [2], prev_l [2], prev_busy [2];
  logic [DW-1:0] prev_d [2];
  int cyc;

  // Stream monitor, sampled mid-cycle
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int k = 0; k < 2; k++) begin
        cap_n[k] <= 0; stab_err[k] <= 0; ovf_err[k] <= 0; occ[k] <= 0;
        rd_cnt[k] <= 0; rd_first[k] <= -1; rd_lastc[k] <= -1;
        busy_fall[k] <= -1; prev_stall[k] <= 1'b0; prev_busy[k] <= 1'b0;
        prev_d[k] <= '0; prev_l[k] <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
        if (tv[k] && tr[k]) begin
          if (cap_n[k] < 32) begin
            cap_d[k][cap_n[k]] <= td[k];
            cap_l[k][cap_n[k]] <= tl[k];
            cap_c[k][cap_n[k]] <= cyc;
          end
          cap_n[k] <= cap_n[k] + 1;
        end
        if (prev_stall[k] && (!tv[k] || td[k] != prev_d[k] || tl[k] != prev_l[k]))
          stab_err[k] <= stab_err[k] + 1;
        if (re[k] && occ[k] >= 2) ovf_err[k] <= ovf_err[k] + 1;
        occ[k] <= occ[k] + (re[k] ? 1 : 0) - ((tv[k] && tr[k]) ? 1 : 0);
        if (re[k]) begin
          if (rd_cnt[k] == 0) rd_first[k] <= cyc;
          rd_lastc[k] <= cyc;
          rd_cnt[k] <= rd_cnt[k] + 1;
        end
        if (prev_busy[k] && !bs[k]) busy_fall[k] <= cyc;
        prev_busy[k]  <= bs[k];
        prev_stall[k] <= tv[k] && !tr[k];
        prev_d[k]     <= td[k];
        prev_l[k]     <= tl[k];
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    if_a.m_axis_tready = 1'b0; if_b.m_axis_tready = 1'b0;
    wp[0] = 0; wp[1] = 0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push(input int k, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[k][wp[k] % 64] = DW'(base + i);
      wp[k] = wp[k] + 1;
    end
  endtask

  task automatic wait_beats(input int k, input int n, input int budget, input string nm);
    int t;
    t = 0;
    while (cap_n[k] < n && t < budget) begin step(); t++; end
    n_chk++;
    if (cap_n[k] < n) begin
      n_fail++;
      $display("FAIL %s timeout: beats got %0d want %0d", nm, cap_n[k], n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({if_a.m_axis_tvalid, if_a.m_axis_tlast, if_a.fifo_rd_en, busy_a} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000",
        {if_a.m_axis_tvalid, if_a.m_axis_tlast, if_a.fifo_rd_en, busy_a});
    end
    n_chk++;
    if (if_a.m_axis_tdata !== 16'h0) begin
      n_fail++; $display("FAIL reset_tdata: got %h want 0000", if_a.m_axis_tdata);
    end
    n_chk++;
    if ({wc_a, pc_a} !== 64'h0) begin
      n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", wc_a, pc_a);
    end
  endtask

  task automatic test_stream();
    int bad;
    do_reset();
    push(0, 0, 16);
    en_a = 1'b1; if_a.m_axis_tready = 1'b1;
    wait_beats(0, 16, 100, "stream");
    repeat (3) step();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (cap_d[0][i] !== DW'(i)) bad++;
      if (cap_l[0][i] !== ((i == 7) || (i == 15))) bad++;
      if (i > 0 && cap_c[0][i] != cap_c[0][i-1] + 1) bad++;
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL stream_beats: errors %0d want 0", bad); end
    n_chk++;
    if (rd_cnt[0] !== 16 || rd_lastc[0] - rd_first[0] !== 15) begin
      n_fail++; $display("FAIL stream_rd_en: count %0d span %0d want 16/15",
        rd_cnt[0], rd_lastc[0] - rd_first[0]);
    end
    n_chk++;
    if (wc_a !== 32'd16 || pc_a !== 32'd2) begin
      n_fail++; $display("FAIL stream_counts: got %0d/%0d want 16/2", wc_a, pc_a);
    end
  endtask

  task automatic test_backpressure();
    int bad, c;
    do_reset();
    push(0, 16'h40, 16);
    en_a = 1'b1;
    c = 0;
    while (cap_n[0] < 16 && c < 200) begin
      if_a.m_axis_tready = (c % 4 == 0) || (c % 4 == 3);
      step(); c++;
    end
    if_a.m_axis_tready = 1'b0;
    repeat (4) step();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (cap_d[0][i] !== DW'(16'h40 + i)) bad++;
      if (cap_l[0][i] !== ((i == 7) || (i == 15))) bad++;
    end
    n_chk++;
    if (cap_n[0] !== 16 || bad !== 0) begin
      n_fail++; $display("FAIL bp_data: beats %0d errors %0d want 16/0", cap_n[0], bad);
    end
    n_chk++;
    if (stab_err[0] !== 0) begin
      n_fail++; $display("FAIL bp_stable: violations %0d want 0", stab_err[0]);
    end
    n_chk++;
    if (ovf_err[0] !== 0) begin
      n_fail++; $display("FAIL bp_occ2_pop: violations %0d want 0", ovf_err[0]);
    end
    n_chk++;
    if (pc_a !== 32'd2) begin n_fail++; $display("FAIL bp_pkts: got %0d want 2", pc_a); end
  endtask

  task automatic test_drain();
    int bad;
    do_reset();
    push(0, 0, 16);
    en_a = 1'b1; if_a.m_axis_tready = 1'b1;
    wait_beats(0, 3, 50, "drain_start");
    en_a = 1'b0;
    wait_beats(0, 8, 50, "drain_end");
    repeat (10) step();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (cap_d[0][i] !== DW'(i)) bad++;
      if (cap_l[0][i] !== (i == 7)) bad++;
    end
    n_chk++;
    if (cap_n[0] !== 8 || bad !== 0) begin
      n_fail++; $display("FAIL drain_beats: beats %0d errors %0d want 8/0", cap_n[0], bad);
    end
    n_chk++;
    if (if_a.fifo_empty !== 1'b0 || if_a.fifo_rd_data !== 16'h0008) begin
      n_fail++; $display("FAIL drain_fifo_head: empty %b head %h want 0/0008",
        if_a.fifo_empty, if_a.fifo_rd_data);
    end
    n_chk++;
    if (busy_a !== 1'b0 || busy_fall[0] !== cap_c[0][7] + 1) begin
      n_fail++; $display("FAIL drain_busy: busy %b fall cycle %0d want 0/%0d",
        busy_a, busy_fall[0], cap_c[0][7] + 1);
    end
  endtask

  task automatic test_starvation();
    int bad;
    do_reset();
    push(0, 16'h80, 5);
    en_a = 1'b1; if_a.m_axis_tready = 1'b1;
    repeat (10) step();
    push(0, 16'h85, 3);
    wait_beats(0, 8, 50, "starve");
    repeat (3) step();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (cap_d[0][i] !== DW'(16'h80 + i)) bad++;
      if (cap_l[0][i] !== (i == 7)) bad++;
    end
    n_chk++;
    if (cap_n[0] !== 8 || bad !== 0) begin
      n_fail++; $display("FAIL starve_beats: beats %0d errors %0d want 8/0", cap_n[0], bad);
    end
    n_chk++;
    if ((cap_c[0][5] - cap_c[0][4] > 1) !== 1'b1) begin
      n_fail++; $display("FAIL starve_gap: gap %0d want >1", cap_c[0][5] - cap_c[0][4]);
    end
    n_chk++;
    if (pc_a !== 32'd1 || wc_a !== 32'd8) begin
      n_fail++; $display("FAIL starve_counts: got %0d/%0d want 8/1", wc_a, pc_a);
    end
  endtask

  task automatic test_packet_len1();
    int bad;
    do_reset();
    push(1, 16'hA0, 4);
    en_b = 1'b1; if_b.m_axis_tready = 1'b1;
    wait_beats(1, 4, 50, "pl1");
    repeat (3) step();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (cap_d[1][i] !== DW'(16'hA0 + i)) bad++;
      if (cap_l[1][i] !== 1'b1) bad++;
    end
    n_chk++;
    if (cap_n[1] !== 4 || bad !== 0) begin
      n_fail++; $display("FAIL pl1_beats: beats %0d errors %0d want 4/0", cap_n[1], bad);
    end
    n_chk++;
    if (pc_b !== 32'd4 || wc_b !== 32'd4) begin
      n_fail++; $display("FAIL pl1_counts: got %0d/%0d want 4/4", wc_b, pc_b);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    push(0, 16'h200, 16);
    en_a = 1'b1; if_a.m_axis_tready = 1'b0;
    repeat (6) step();
    n_chk++;
    if (occ[0] !== 2 || if_a.m_axis_tdata !== 16'h0200) begin
      n_fail++; $display("FAIL rstmid_pre: occ %0d tdata %h want 2/0200", occ[0], if_a.m_axis_tdata);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({if_a.m_axis_tvalid, if_a.m_axis_tlast, if_a.fifo_rd_en, busy_a} !== 4'b0 ||
        if_a.m_axis_tdata !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_async: ctrl %b tdata %h want 0000/0000",
        {if_a.m_axis_tvalid, if_a.m_axis_tlast, if_a.fifo_rd_en, busy_a}, if_a.m_axis_tdata);
    end
    en_a = 1'b0; wp[0] = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    push(0, 16'h300, 8);
    en_a = 1'b1; if_a.m_axis_tready = 1'b1;
    wait_beats(0, 8, 50, "rstmid_after");
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (cap_d[0][i] !== DW'(16'h300 + i)) bad++;
      if (cap_l[0][i] !== (i == 7)) bad++;
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL rstmid_index: errors %0d want 0", bad); end
  endtask

  initial begin
    if_a.m_axis_tready = 1'b0;
    if_b.m_axis_tready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_starvation();
    test_packet_len1();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
